// File: rtl/deco_frame_buf_if.sv
// deco_frame_buf_if
//   Bundles the turbo-decoder front-end signals: the beat stream
//   (start_i/data_i), the frame hand-off port (frm_valid_o/frm_data_o/
//   frm_ready_i), the result path (res_valid_i/res_data_i -> data_o/done_o)
//   and the error reporting pair (err_o/err_cnt_o).
//   Signal suffixes are given from the frame buffer's point of view.
//   modport slave  : the frame buffer itself
//   modport master : the environment driving it (source + decoder core)
interface deco_frame_buf_if #(
  parameter int DATA_W = 21,
  parameter int BEATS  = 4,
  parameter int RES_W  = 5
);
  localparam int FRAME_W = DATA_W * BEATS;

  logic               start_i;
  logic [DATA_W-1:0]  data_i;
  logic               frm_valid_o;
  logic [FRAME_W-1:0] frm_data_o;
  logic               frm_ready_i;
  logic               res_valid_i;
  logic [RES_W-1:0]   res_data_i;
  logic [RES_W-1:0]   data_o;
  logic               done_o;
  logic               err_o;
  logic [7:0]         err_cnt_o;

  modport slave (
    input  start_i, data_i, frm_ready_i, res_valid_i, res_data_i,
    output frm_valid_o, frm_data_o, data_o, done_o, err_o, err_cnt_o
  );

  modport master (
    output start_i, data_i, frm_ready_i, res_valid_i, res_data_i,
    input  frm_valid_o, frm_data_o, data_o, done_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/deco_frame_buf.sv
// deco_frame_buf
//   Turbo-decoder front end. Assembles BEATS-beat frames from the
//   start_i/data_i stream (beat 0 in the LSBs), queues up to DEPTH complete
//   frames and offers the oldest on a valid/ready port. Core results are
//   registered onto data_o with a one-cycle done_o pulse.
// Ports
//   clk_p_i   : clock, rising edge
//   reset_n_i : asynchronous active-low reset
//   bus       : deco_frame_buf_if.slave (beat stream, frame port,
//               result path, error pulse and saturating error count)
// Build option
//   DECO_FRAME_ERR_EN : when defined, short frames and FIFO-full drops pulse
//   err_o and bump err_cnt_o; otherwise both are tied to zero and such
//   frames are discarded silently.
module deco_frame_buf #(
  parameter int DATA_W = 21,
  parameter int BEATS  = 4,
  parameter int DEPTH  = 4,
  parameter int RES_W  = 5
) (
  input  logic            clk_p_i,
  input  logic            reset_n_i,
  deco_frame_buf_if.slave bus
);
  localparam int FRAME_W = DATA_W * BEATS;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, CAP, WAIT_LOW} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] frame_ins;
  logic               commit;

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   occ_q;
  logic               fifo_full, fifo_valid, pop, push;

  logic [RES_W-1:0]   data_q;
  logic               done_q;

  // Partial frame with the current beat dropped into slot cnt_q. The commit
  // path writes this straight into the FIFO so the last beat costs no cycle.
  always_comb begin
    frame_ins = frame_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CNT_W'(k)) frame_ins[k*DATA_W +: DATA_W] = bus.data_i;
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          frame_d = frame_ins;
          if (BEATS == 1) begin
            commit  = 1'b1;
            state_d = WAIT_LOW;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = CAP;
          end
        end
      end
      CAP: begin
        if (bus.start_i) begin
          frame_d = frame_ins;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            commit  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_LOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Short frame: abandon the partial beats.
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      WAIT_LOW: begin
        // Extra strobe cycles after the last beat are hold cycles.
        if (!bus.start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame FIFO. A pop frees the slot in the same cycle, so a commit into a
  // full FIFO is accepted when the core is taking the head.
  assign fifo_valid = (occ_q != '0);
  assign fifo_full  = (occ_q == OCC_W'(DEPTH));
  assign pop        = fifo_valid && bus.frm_ready_i;
  assign push       = commit && (!fifo_full || pop);

  always_ff @(posedge clk_p_i) begin
    if (push) mem_q[wr_ptr_q] <= frame_ins;
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign bus.frm_valid_o = fifo_valid;
  // Storage is not reset; masking keeps the head at zero whenever empty.
  assign bus.frm_data_o  = fifo_valid ? mem_q[rd_ptr_q] : '0;

  // Result path.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= bus.res_valid_i;
      if (bus.res_valid_i) data_q <= bus.res_data_i;
    end
  end

  assign bus.data_o = data_q;
  assign bus.done_o = done_q;

`ifdef DECO_FRAME_ERR_EN
  logic       short_frame, drop, err_q;
  logic [7:0] err_cnt_q;

  assign short_frame = (state_q == CAP) && !bus.start_i;
  assign drop        = commit && fifo_full && !pop;

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= short_frame || drop;
      if ((short_frame || drop) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = err_cnt_q;
`else
  assign bus.err_o     = 1'b0;
  assign bus.err_cnt_o = '0;
`endif
endmodule

// File: doc/deco_frame_buf.md
# deco_frame_buf

Parametrised front-end for the turbo decoder core. Assembles multi-beat input frames from the `start_i`/`data_i` beat stream, buffers up to DEPTH complete frames in a FIFO, and hands them to the core over a valid/ready port. It also registers the core's results back onto the `data_o`/`done_o` pair. It generalises the fixed 4×21-bit load of the current decoder in beat width, beats per frame, result width and buffering depth. It adds back-pressure and malformed-frame detection.

## Interface
- DATA_W, 21: bits per input beat
- BEATS, 4: beats per frame (≥1); FRAME_W = DATA_W*BEATS (localparam)
- DEPTH, 4: frame FIFO entries, power of 2, ≥2
- RES_W, 5: result width
- clk_p_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  frame-active strobe; high while beats are presented
- data_i  in  DATA_W  input beat, sampled when start_i=1 during capture
- frm_valid_o  out  1  FIFO head valid
- frm_data_o  out  FRAME_W  FIFO head frame
- frm_ready_i  in  1  core accepts head frame
- res_valid_i  in  1  core result strobe
- res_data_i  in  RES_W  core result
- data_o  out  RES_W  registered result, held until next result
- done_o  out  1  one-cycle result pulse
- err_o  out  1  one-cycle malformed/dropped-frame pulse
- err_cnt_o  out  8  saturating error count

## Operation
- Capture FSM:
  - IDLE: start_i=1 captures beat 0 and enters CAP. If BEATS=1, it commits immediately and enters WAIT_LOW.
  - CAP: start_i=1 captures beat cnt. When cnt=BEATS-1, it commits and enters WAIT_LOW. start_i=0 before the last beat makes a short frame: the frame is discarded, an error is raised (see Configuration), and the FSM returns to IDLE.
  - WAIT_LOW: start_i=1 cycles are ignored (hold cycles). start_i=0 returns the FSM to IDLE. A new frame requires at least one start_i=0 cycle.
- Beat ordering: beat k is placed at frame bits [(k+1)*DATA_W-1 -: DATA_W]. Beat 0 goes to the LSBs.
- Commit pushes the frame into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the frame is dropped and an error is raised.
  - Push and pop in the same cycle are legal when the FIFO is full or non-empty.
- FIFO output:
  - A pop happens when frm_valid_o & frm_ready_i.
  - frm_data_o stays stable while valid and not ready.
  - frm_valid_o=0 when the FIFO is empty.
  - Frames come out in push order. Pointers wrap modulo DEPTH, with an occupancy counter of log2(DEPTH)+1 bits.
- Result path: when res_valid_i=1, data_o is loaded from res_data_i and done_o is set for one cycle. Back-to-back res_valid_i gives back-to-back done_o pulses.
- err_cnt_o saturates at 255.

## Timing
- Reset values: frm_valid_o=0, frm_data_o=0, data_o=0, done_o=0, err_o=0, err_cnt_o=0, FIFO empty, FSM in IDLE.
- Reset asserted mid-capture or mid-drain discards the partial frame and all stored frames immediately (asynchronous).
- Beat-to-FIFO latency: frm_valid_o rises on the edge after the edge that captures the last beat, when the FIFO was empty.
- Result latency: done_o and data_o update on the edge after the edge that samples res_valid_i.
- err_o pulses on the edge after the short-frame or drop event is detected.
- The capture side has no back-pressure. The source sees drops only via err_o.

## Configuration
- DECO_FRAME_ERR_EN defined:
  - short frames and FIFO-full drops pulse err_o and increment err_cnt_o.
- Not defined:
  - err_o and err_cnt_o are tied to 0 and the counter logic is removed.
  - Short and dropped frames are still discarded silently; capture and FIFO behaviour are otherwise identical.

## Test plan
- Single frame, DATA_W=21, BEATS=4, frm_ready_i=1. Beats 0x00001, 0x00002, 0x00003, 0x00004 are followed by one hold cycle, then start_i=0. Required: frm_valid_o is high for one cycle, one edge after beat 4, and frm_data_o={0x00004,0x00003,0x00002,0x00001}.
- Back-pressure, frm_ready_i=0, 5 frames tagged 1..5 in beat 0. Required: FIFO full after frame 4; frame 5 dropped; err_o pulses once; err_cnt_o=1 (ERR_EN). Then set frm_ready_i=1. Required: frames 1,2,3,4 pop in order on consecutive cycles.
- Short frame: start_i high for 2 beats, then low. Required: no push, err_cnt_o=1. The following full frame is captured correctly.
- Result path: res_valid_i=1 with res_data_i=5'b10110. Required: next edge done_o=1 for one cycle; data_o=10110 held afterwards. Two back-to-back results give two consecutive done_o pulses.
- Reset (reset_n_i=0) after beat 2 of a frame. Required: all outputs return to their reset values at once. The next frame after release completes with correct data.
- Full FIFO with a commit and frm_ready_i=1 in the same cycle. Required: no drop, err_o=0, occupancy stays DEPTH, and the new frame appears last in order.
